// File: rtl/ad4008_pkg.sv
// rtl/ad4008_pkg.sv - shared AD4008 word width and responder state encoding
package ad4008_pkg;
   localparam int ADC_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      WAIT_CNV_LOW,
      SHIFT
   } state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with 1-cycle rise/fall pulses
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;
endmodule

// File: rtl/ad4008_responder.sv
// rtl/ad4008_responder.sv - clocked AD4008 ADC model serving queued samples over cnv/sck/sdo
module ad4008_responder
   import ad4008_pkg::*;
#(
   parameter int ADC_WIDTH   = ADC_WIDTH_DEFAULT,
   parameter int CONV_CYCLES = 30,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 cnv,
   input  logic                 sck,
   output logic                 sdo,
   input  logic [ADC_WIDTH-1:0] sample_data,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 busy,
   output logic                 underrun,
   output logic                 abort,
   output logic [15:0]          conv_count
);
   localparam int CCW = $clog2(CONV_CYCLES + 1);
   localparam int BCW = (ADC_WIDTH > 1) ? $clog2(ADC_WIDTH) : 1;

   logic cnv_level, cnv_rise, cnv_fall;
   logic sck_level, sck_rise, sck_fall;
   logic unused_sync;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
      .clk(clk), .rst_n(aresetn), .d_in(cnv),
      .level(cnv_level), .rise(cnv_rise), .fall(cnv_fall)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
      .clk(clk), .rst_n(aresetn), .d_in(sck),
      .level(sck_level), .rise(sck_rise), .fall(sck_fall)
   );

   // Data moves only on sck falls; the reader samples on the rising side.
   assign unused_sync = sck_level ^ sck_rise;

   state_e               state_q, state_d;
   logic [ADC_WIDTH-1:0] shift_q, shift_d;
   logic [ADC_WIDTH-1:0] last_q, last_d;
   logic [ADC_WIDTH-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [CCW-1:0]       conv_cnt_q, conv_cnt_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 sdo_q, sdo_d;
   logic                 busy_q, busy_d;
   logic                 underrun_q, underrun_d;
   logic                 abort_q, abort_d;
   logic [15:0]          count_q, count_d;
   logic                 start;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      last_d      = last_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      conv_cnt_d  = conv_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      sdo_d       = sdo_q;
      busy_d      = busy_q;
      underrun_d  = 1'b0;
      abort_d     = 1'b0;
      count_d     = count_q;
      start       = 1'b0;

      if (sample_valid && !hold_full_q) begin
         hold_d      = sample_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            sdo_d = 1'b0;
            start = cnv_rise;
         end
         CONVERT: begin
            sdo_d = 1'b0;
            if (conv_cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = WAIT_CNV_LOW;
            end else begin
               conv_cnt_d = conv_cnt_q - CCW'(1);
            end
         end
         WAIT_CNV_LOW: begin
            sdo_d = 1'b0;
            if (!cnv_level || cnv_fall) begin
               state_d   = SHIFT;
               sdo_d     = shift_q[ADC_WIDTH-1];
               bit_cnt_d = BCW'(ADC_WIDTH - 1);
            end
         end
         SHIFT: begin
            if (cnv_rise) begin
               abort_d = 1'b1;
               start   = 1'b1;
            end else if (sck_fall) begin
               if (bit_cnt_q == '0) begin
                  sdo_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  shift_d   = shift_q << 1;
                  sdo_d     = shift_q[ADC_WIDTH-2];
                  bit_cnt_d = bit_cnt_q - BCW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A word accepted this cycle is not yet in hold_full_q, so it waits for the next conversion.
      if (start) begin
         state_d    = CONVERT;
         sdo_d      = 1'b0;
         busy_d     = 1'b1;
         conv_cnt_d = CCW'(CONV_CYCLES - 1);
         count_d    = count_q + 16'd1;
         if (hold_full_q) begin
            shift_d     = hold_q;
            last_d      = hold_q;
            hold_full_d = 1'b0;
         end else begin
            shift_d    = last_q;
            underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         last_q      <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         conv_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         sdo_q       <= 1'b0;
         busy_q      <= 1'b0;
         underrun_q  <= 1'b0;
         abort_q     <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         last_q      <= last_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         conv_cnt_q  <= conv_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sdo_q       <= sdo_d;
         busy_q      <= busy_d;
         underrun_q  <= underrun_d;
         abort_q     <= abort_d;
         count_q     <= count_d;
      end
   end

   assign sdo          = sdo_q;
   assign sample_ready = ~hold_full_q;
   assign busy         = busy_q;
   assign underrun     = underrun_q;
   assign abort        = abort_q;
   assign conv_count   = count_q;
endmodule

// File: tb/tb_ad4008_responder.sv
// tb/tb_ad4008_responder.sv - directed and randomized reader bench for ad4008_responder
module tb_ad4008_responder;
   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cnv = 1'b0;
   logic        sck = 1'b0;
   logic        sdo;
   logic [15:0] sample_data = 16'h0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        busy;
   logic        underrun;
   logic        abort;
   logic [15:0] conv_count;

   ad4008_responder dut (
      .clk(clk), .aresetn(aresetn), .cnv(cnv), .sck(sck), .sdo(sdo),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .busy(busy), .underrun(underrun),
      .abort(abort), .conv_count(conv_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int und_cnt = 0;
   int abt_cnt = 0;

   always @(negedge clk) begin
      if (underrun === 1'b1) und_cnt++;
      if (abort === 1'b1) abt_cnt++;
   end

   // Reference model: one-deep holding slot, last served word, conversion counter.
   bit          m_full;
   logic [15:0] m_hold, m_last, m_count;

   task automatic model_reset();
      m_full = 0; m_hold = 16'h0; m_last = 16'h0; m_count = 16'h0;
   endtask

   task automatic model_conv(output logic [15:0] served, output int exp_und);
      m_count = m_count + 16'd1;
      if (m_full) begin
         served = m_hold; m_last = m_hold; m_full = 0; exp_und = 0;
      end else begin
         served = m_last; exp_und = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      bit ok = 0;
      @(negedge clk);
      sample_data  = w;
      sample_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (sample_ready === 1'b1) begin ok = 1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      if (ok) begin m_full = 1; m_hold = w; end
      else chk("push_timeout", 0, 1);
   endtask

   task automatic start_conv(input bit tog, output int cyc);
      bit seen = 0;
      int ntog = 0;
      cyc = 0;
      @(negedge clk);
      cnv = 1'b1;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (tog && i >= 6 && (i % 3) == 0 && ntog < 8) begin sck = ~sck; ntog++; end
         if (busy === 1'b1) begin seen = 1; cyc++; end
         else if (seen) break;
      end
      if (!seen) chk("busy_timeout", 0, 1);
   endtask

   task automatic lower_and_read(input int nfalls, output logic [15:0] w);
      @(negedge clk);
      cnv = 1'b0;
      repeat (8) @(negedge clk);
      w = 16'h0;
      for (int i = 0; i < nfalls; i++) begin
         sck = 1'b1;
         repeat (4) @(negedge clk);
         w = {w[14:0], sdo};
         sck = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic full_conv(input string tag, input bit tog);
      logic [15:0] exp_w, got_w;
      int eu, u0, cyc;
      u0 = und_cnt;
      start_conv(tog, cyc);
      model_conv(exp_w, eu);
      lower_and_read(16, got_w);
      repeat (4) @(negedge clk);
      chk({tag, "_word"}, got_w, exp_w);
      chk({tag, "_busy_cycles"}, cyc, 30);
      chk({tag, "_underrun"}, und_cnt - u0, eu);
      chk({tag, "_count"}, conv_count, m_count);
      chk({tag, "_sdo_idle"}, sdo, 1'b0);
      if (tog) chk({tag, "_first_bit"}, got_w[15], exp_w[15]);
   endtask

   initial begin
      logic [15:0] w, exp_w;
      int eu, cyc, a0, u0;
      bit rdy_seen;

      model_reset();
      #1;
      chk("rst_sdo", sdo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", sample_ready, 1);
      chk("rst_underrun", underrun, 0);
      chk("rst_abort", abort, 0);
      chk("rst_count", conv_count, 0);
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
      repeat (3) @(negedge clk);

      push(16'hA5C3);
      full_conv("t1", 0);
      full_conv("t2", 0);

      push(16'h1234);
      u0 = und_cnt;
      start_conv(0, cyc);
      model_conv(exp_w, eu);
      lower_and_read(5, w);
      chk("t3_partial", w[4:0], exp_w[15:11]);
      chk("t3_first_underrun", und_cnt - u0, eu);
      a0 = abt_cnt;
      full_conv("t3_after_abort", 0);
      chk("t3_abort", abt_cnt - a0, 1);

      push(16'h8001);
      full_conv("t4", 1);

      push(16'h5555);
      start_conv(0, cyc);
      model_conv(exp_w, eu);
      push(16'h7777);
      lower_and_read(8, w);
      chk("t5_partial", w[7:0], exp_w[15:8]);
      chk("t5_ready_full", sample_ready, 0);
      @(negedge clk);
      #2 aresetn = 1'b0;
      #1;
      model_reset();
      chk("t5_sdo", sdo, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ready", sample_ready, 1);
      chk("t5_count", conv_count, 0);
      @(negedge clk);
      aresetn = 1'b1;
      repeat (3) @(negedge clk);
      push(16'h00FF);
      full_conv("t5", 0);

      push(16'h0000);
      @(negedge clk);
      sample_data  = 16'hFFFF;
      sample_valid = 1'b1;
      rdy_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (sample_ready !== 1'b0) rdy_seen = 1;
      end
      sample_valid = 1'b0;
      chk("t6_ready_held_low", rdy_seen, 0);
      full_conv("t6a", 0);
      push(16'hFFFF);
      full_conv("t6b", 0);
      push(16'h8001);
      full_conv("t6c", 0);

      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 3) != 0) push(16'($urandom));
         full_conv("rand", 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
